io_platform: RTL and testbench

//  Platform-side responder for the CPU I/O port protocol. It implements the reserved ports:
//  0 halt, 2 stdin, 3 stdout, 4 irq status, 5 irq mask.
//  It buffers a byte-stream input into an RX FIFO and drains a TX FIFO to a byte-stream output.
//  It drives the CPU irq line. It sits between the cpu instance and the external byte channels.

---
 rtl/io_pkg.sv | 17 +
 rtl/byte_fifo.sv | 64 ++++++
 rtl/io_platform.sv | 113 +++++++++++
 tb/tb_io_platform.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the platform I/O responder: reserved port numbers,
// interrupt bit positions and the stdin-empty read value.
package io_pkg;

    localparam logic [8:0] PORT_HALT    = 9'd0;
    localparam logic [8:0] PORT_IRQVEC  = 9'd1;
    localparam logic [8:0] PORT_STDIN   = 9'd2;
    localparam logic [8:0] PORT_STDOUT  = 9'd3;
    localparam logic [8:0] PORT_IRQSTAT = 9'd4;
    localparam logic [8:0] PORT_IRQMASK = 9'd5;

    localparam int IRQ_RX = 0;
    localparam int IRQ_TX = 1;

    localparam logic [15:0] STDIN_EMPTY = 16'h8000;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous 8-bit FIFO. Push while full and pop while empty are ignored,
// judged on pre-edge occupancy; *_next flags describe the post-edge state.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       full_next,
    output logic       empty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign full_next  = (count_next == CW'(DEPTH));
    assign empty_next = (count_next == '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_platform.sv
// Platform-side responder for the CPU I/O port protocol: decodes the reserved
// ports, buffers the byte channels in RX/TX FIFOs and drives the irq line.
module io_platform
    import io_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  io_port,
    input  logic [15:0] data_out,
    input  logic        data_out_valid,
    output logic [15:0] data_in,
    output logic        irq,
    output logic        halt,
    output logic [15:0] halt_code,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready
);

    // Byte channels: a byte moves on a posedge where valid && ready are both
    // high; valid does not wait on ready, and there are no partial transfers.

    logic       rx_full, rx_empty, rx_full_next, rx_empty_next;
    logic       tx_full, tx_empty, tx_full_next, tx_empty_next;
    logic [7:0] rx_head;
    logic [1:0] mask;
    logic [1:0] mask_next;
    logic [1:0] pend;
    logic [1:0] pend_next;
    logic       wr_stdin, wr_stdout, wr_halt, wr_mask;

    assign wr_halt   = data_out_valid && (io_port == PORT_HALT);
    assign wr_stdin  = data_out_valid && (io_port == PORT_STDIN);
    assign wr_stdout = data_out_valid && (io_port == PORT_STDOUT);
    assign wr_mask   = data_out_valid && (io_port == PORT_IRQMASK);

    assign rx_ready = !rx_full && !reset;
    assign tx_valid = !tx_empty;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (rx_valid && rx_ready),
        .din        (rx_byte),
        .pop        (wr_stdin),
        .head       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .full_next  (rx_full_next),
        .empty_next (rx_empty_next)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (wr_stdout),
        .din        (data_out[7:0]),
        .pop        (tx_ready),
        .head       (tx_byte),
        .full       (tx_full),
        .empty      (tx_empty),
        .full_next  (tx_full_next),
        .empty_next (tx_empty_next)
    );

    assign mask_next = wr_mask ? data_out[1:0] : mask;

    always_comb begin
        pend              = '0;
        pend[IRQ_RX]      = !rx_empty;
        pend[IRQ_TX]      = !tx_full;
        pend              = pend & mask;
        pend_next         = '0;
        pend_next[IRQ_RX] = !rx_empty_next;
        pend_next[IRQ_TX] = !tx_full_next;
        pend_next         = pend_next & mask_next;
    end

    always_comb begin
        data_in = 16'h0000;
        case (io_port)
            PORT_STDIN:   data_in = rx_empty ? STDIN_EMPTY : {8'h00, rx_head};
            PORT_STDOUT:  data_in = {15'b0, !tx_full};
            PORT_IRQSTAT: data_in = {14'b0, pend};
            PORT_IRQMASK: data_in = {14'b0, mask};
            default:      data_in = 16'h0000;
        endcase
    end

    // irq is registered from the post-edge state so it tracks the visible pend.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask      <= '0;
            irq       <= 1'b0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            mask <= mask_next;
            irq  <= |pend_next;
            if (wr_halt) begin
                halt      <= 1'b1;
                halt_code <= data_out;
            end
        end
    end

endmodule

// File: tb/tb_io_platform.sv
// Bench for io_platform: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_io_platform;

    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [8:0]  io_port;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [15:0] data_in;
    logic        irq;
    logic        halt;
    logic [15:0] halt_code;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;

    io_platform #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_port        (io_port),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_in        (data_in),
        .irq            (irq),
        .halt           (halt),
        .halt_code      (halt_code),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_byte        (tx_byte),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // reference model
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [1:0]  m_mask;
    logic        m_halt;
    logic [15:0] m_code;

    function automatic logic [1:0] m_pend();
        logic [1:0] p;
        p[0] = (rx_q.size() != 0);
        p[1] = (tx_q.size() < TX_DEPTH);
        return p & m_mask;
    endfunction

    function automatic logic [15:0] m_data_in(logic [8:0] p);
        case (p)
            9'd2:    return (rx_q.size() == 0) ? 16'h8000 : {8'h00, rx_q[0]};
            9'd3:    return {15'b0, tx_q.size() < TX_DEPTH};
            9'd4:    return {14'b0, m_pend()};
            9'd5:    return {14'b0, m_mask};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            rx_q.delete();
            tx_q.delete();
            m_mask = 2'b00;
            m_halt = 1'b0;
            m_code = 16'h0000;
        end else begin
            bit rx_full_pre, rx_empty_pre, tx_full_pre, tx_empty_pre;
            rx_full_pre  = (rx_q.size() == RX_DEPTH);
            rx_empty_pre = (rx_q.size() == 0);
            tx_full_pre  = (tx_q.size() == TX_DEPTH);
            tx_empty_pre = (tx_q.size() == 0);
            if (tx_ready && !tx_empty_pre) void'(tx_q.pop_front());
            if (data_out_valid && io_port == 9'd3 && !tx_full_pre) tx_q.push_back(data_out[7:0]);
            if (data_out_valid && io_port == 9'd2 && !rx_empty_pre) void'(rx_q.pop_front());
            if (rx_valid && !rx_full_pre) rx_q.push_back(rx_byte);
            if (data_out_valid && io_port == 9'd5) m_mask = data_out[1:0];
            if (data_out_valid && io_port == 9'd0) begin
                m_halt = 1'b1;
                m_code = data_out;
            end
        end
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // per-cycle compare against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("m_data_in",   data_in,            m_data_in(io_port));
            check("m_irq",       {15'b0, irq},       {15'b0, |m_pend()});
            check("m_halt",      {15'b0, halt},      {15'b0, m_halt});
            check("m_halt_code", halt_code,          m_code);
            check("m_rx_ready",  {15'b0, rx_ready},  {15'b0, !reset && rx_q.size() < RX_DEPTH});
            check("m_tx_valid",  {15'b0, tx_valid},  {15'b0, tx_q.size() != 0});
            if (tx_q.size() != 0) check("m_tx_byte", {8'h00, tx_byte}, {8'h00, tx_q[0]});
        end
    end

    // driver tasks: inputs change 1 time unit after a posedge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(logic [8:0] p, logic [15:0] d);
        io_port        = p;
        data_out       = d;
        data_out_valid = 1'b1;
        cyc();
        data_out_valid = 1'b0;
    endtask

    task automatic rd(logic [8:0] p, logic [15:0] exp, string name);
        io_port = p;
        @(negedge clock);
        check(name, data_in, exp);
        cyc();
    endtask

    task automatic rx_push(logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic at_neg(string name, logic [15:0] act_sel, logic [15:0] exp);
        check(name, act_sel, exp);
    endtask

    initial begin
        reset          = 1'b1;
        io_port        = 9'd7;
        data_out       = 16'h0000;
        data_out_valid = 1'b0;
        rx_byte        = 8'h00;
        rx_valid       = 1'b0;
        tx_ready       = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        @(negedge clock);
        check("rx_ready_in_reset", {15'b0, rx_ready}, 16'h0000);
        cyc();
        reset = 1'b0;
        cyc();

        // 1. reset values
        rd(9'd2, 16'h8000, "rst_stdin");
        rd(9'd3, 16'h0001, "rst_stdout");
        rd(9'd4, 16'h0000, "rst_irqstat");
        rd(9'd5, 16'h0000, "rst_irqmask");
        rd(9'd9, 16'h0000, "rst_other");
        @(negedge clock);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
        cyc();

        // 2. RX path
        rx_push(8'h41);
        rx_push(8'h42);
        rd(9'd2, 16'h0041, "rx_first");
        wr(9'd2, 16'h0000);
        rd(9'd2, 16'h0042, "rx_second");
        wr(9'd2, 16'h0000);
        rd(9'd2, 16'h8000, "rx_empty");
        wr(9'd2, 16'h0000);
        rd(9'd2, 16'h8000, "rx_pop_empty_ignored");

        // RX fill to full with a continuous stream; 5th byte is held off
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_byte = 8'h60 + 8'(i);
            cyc();
        end
        @(negedge clock);
        check("rx_full_ready", {15'b0, rx_ready}, 16'h0000);
        cyc();
        // push and pop together while full: pop frees a slot, push refused this edge
        io_port = 9'd2; data_out_valid = 1'b1; rx_byte = 8'h70;
        cyc();
        data_out_valid = 1'b0;
        // push and pop together on non-empty FIFO
        io_port = 9'd2; data_out_valid = 1'b1; rx_byte = 8'h71;
        cyc();
        data_out_valid = 1'b0;
        rx_valid = 1'b0;
        rd(9'd2, 16'h0062, "rx_after_pushpop");
        for (int i = 0; i < 4; i++) wr(9'd2, 16'h0000);
        rd(9'd2, 16'h8000, "rx_drained");

        // 3. TX path with overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(9'd3, 16'(i));
        rd(9'd3, 16'h0000, "tx_full_after_4");
        wr(9'd3, 16'h0005);
        rd(9'd3, 16'h0000, "tx_full_after_5");
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            check("tx_drain_valid", {15'b0, tx_valid}, 16'h0001);
            check("tx_drain_byte", {8'h00, tx_byte}, 16'(i));
        end
        @(negedge clock);
        check("tx_drain_done", {15'b0, tx_valid}, 16'h0000);
        cyc();

        // 4. RX interrupt
        wr(9'd5, 16'h0001);
        rx_push(8'h10);
        @(negedge clock);
        check("irq_rx_set", {15'b0, irq}, 16'h0001);
        cyc();
        rd(9'd4, 16'h0001, "irqstat_rx");
        wr(9'd2, 16'h0000);
        @(negedge clock);
        check("irq_rx_clear", {15'b0, irq}, 16'h0000);
        cyc();

        // 5. TX interrupt
        tx_ready = 1'b0;
        wr(9'd5, 16'h0002);
        @(negedge clock);
        check("irq_tx_set", {15'b0, irq}, 16'h0001);
        cyc();
        for (int i = 0; i < 4; i++) wr(9'd3, 16'h00A0 + 16'(i));
        @(negedge clock);
        check("irq_tx_clear", {15'b0, irq}, 16'h0000);
        cyc();
        rd(9'd4, 16'h0000, "irqstat_tx_full");
        // simultaneous push while full and drain: push must be dropped
        tx_ready = 1'b1;
        wr(9'd3, 16'h00BB);
        tx_ready = 1'b0;
        rd(9'd5, 16'h0002, "mask_read");
        tx_ready = 1'b1;
        repeat (5) cyc();

        // 6. halt, then reset mid-RX-fill
        wr(9'd0, 16'h002A);
        @(negedge clock);
        check("halt_set", {15'b0, halt}, 16'h0001);
        check("halt_code", halt_code, 16'h002A);
        cyc();
        wr(9'd1, 16'hFFFF);
        wr(9'd4, 16'hFFFF);
        @(negedge clock);
        check("halt_sticky", {15'b0, halt}, 16'h0001);
        cyc();
        rx_push(8'h55);
        rx_byte  = 8'h56;
        rx_valid = 1'b1;
        reset    = 1'b1;
        cyc();
        rx_valid = 1'b0;
        reset    = 1'b0;
        cyc();
        rd(9'd2, 16'h8000, "post_reset_stdin");
        rd(9'd5, 16'h0000, "post_reset_mask");
        @(negedge clock);
        check("post_reset_halt", {15'b0, halt}, 16'h0000);
        check("post_reset_code", halt_code, 16'h0000);
        check("post_reset_irq", {15'b0, irq}, 16'h0000);
        check("post_reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
        cyc();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
